memory: RTL and testbench
=========================

Name: memory

Overview:
- Single-port synchronous-write, asynchronous-read RAM of 2**AWIDTH words × DWIDTH bits, for the RISC CPU.
- One shared bidirectional data bus: driven by the block on read, by the bus master on write.
- Sits between the CPU address/control outputs and the system data bus.

Parameters:
- AWIDTH, 5, address width; depth = 2**AWIDTH (32 words).
- DWIDTH, 8, data word width in bits.

Ports:
- clk  input  1  clock; all writes on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- wr  input  1  write enable, active-high.
- rd  input  1  read enable, active-high; also output-enable for data.
- addr  input  AWIDTH  word address, selects one location for read or write.
- data  inout  DWIDTH  bidirectional data bus.

Behaviour:
- Storage: array mem[0 .. 2**AWIDTH-1] of DWIDTH bits.
- Reset:
  - While rst=0, all locations are cleared to 0 asynchronously (no clock needed).
  - data is released to high-Z.
  - Writes are blocked.
  - After rst returns to 1, normal operation starts at the next rising clk edge.
- Write:
  - On rising clk with rst=1, wr=1 and rd=0: mem[addr] <= data.
  - The value written is whatever is on the bus at that edge.
- Read:
  - Combinational: while rd=1 and rst=1, data is driven with mem[addr]. Zero-cycle latency; follows addr changes immediately.
  - A write followed by a read of the same address returns the new value in the next cycle.
- Bus release: when rd=0, data is high-Z at all DWIDTH bits. The block never drives data while rd=0.
- Simultaneous wr=1 and rd=1: read has priority. data is driven, the write is suppressed and memory is unchanged.
- Idle (wr=0, rd=0): no state change, bus high-Z.
- Address range: full 2**AWIDTH decode with no aliasing. Addresses 0 and all-ones are ordinary locations.
- Bit widths: no arithmetic; data is stored and returned bit-exact, including all-ones and all-zeros.
- X/Z on addr or wr during a write: no requirement on the contents of the affected location; other locations are unaffected.

Optional Feature:
- Macro: MEMORY_COLLISION_EN.
- With the macro defined:
  - Adds output port collision (1 bit).
  - Registered on rising clk: collision <= wr & rd; held 1 for exactly the cycle following each edge where both were high.
  - Cleared to 0 asynchronously by rst=0.
- Without the macro: port absent, no extra logic; wr&rd still follows the read-priority rule.

Decomposition:
- Shared package memory_pkg:
  - Default constants MEM_AWIDTH=5 and MEM_DWIDTH=8.
  - Typedefs mem_addr_t and mem_word_t built from those constants.
- Sub-module: none required; the array, write process and tri-state driver fit in one module.
- A tri-state bus driver memory_bus_drv (enable, in, inout) may be split out if the bus pattern is reused elsewhere; it is not mandatory.

Test Plan:
- Reset: hold rst=0 for 2 cycles, then rst=1, rd=1, addr=5'd7 -> data==8'h00; with rd=0 -> data is 8'hzz.
- Boundary write/read: write 8'hFF to addr 5'b00000 and 8'h00 to addr 5'b11111 (wr=1, rd=0, bus master drives). Then read (wr=0, rd=1, master releases bus) -> addr 0 returns 8'hFF, addr 31 returns 8'h00.
- Sweep: write data=k to addr=31-k for k=0..30, then read back each address -> data==31-addr, with no aliasing.
- Collision: mem[3]=8'hA5; drive wr=1, rd=1, addr=3, master releases the bus -> data==8'hA5 and mem[3] stays 8'hA5. With MEMORY_COLLISION_EN, collision==1 for one cycle.
- Mid-operation reset: after writing 8'h3C to addr 9, pulse rst=0 between clock edges -> data high-Z immediately; after release, reading addr 9 returns 8'h00.
- Bus release: rd toggles 1->0 with addr stable -> data goes from mem[addr] to 8'hzz in the same time step; no clock dependence.

Source files
------------

// File: rtl/memory_pkg.sv
// Shared constants and word/address types for the CPU memory block.
package memory_pkg;

    localparam int MEM_AWIDTH = 5;
    localparam int MEM_DWIDTH = 8;

    typedef logic [MEM_AWIDTH-1:0] mem_addr_t;
    typedef logic [MEM_DWIDTH-1:0] mem_word_t;

endpackage : memory_pkg

// File: rtl/memory.sv
// Single-port RAM: synchronous write, combinational read onto a shared tri-state bus.
// Optional MEMORY_COLLISION_EN adds a registered wr&rd collision flag.
module memory
    import memory_pkg::*;
#(
    parameter int AWIDTH = MEM_AWIDTH,
    parameter int DWIDTH = MEM_DWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic              rd,
    input  logic [AWIDTH-1:0] addr,
    inout  wire  [DWIDTH-1:0] data
`ifdef MEMORY_COLLISION_EN
    ,
    output logic              collision
`endif
);

    localparam int DEPTH = 1 << AWIDTH;

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [DWIDTH-1:0] mem_d [DEPTH];
    logic              wr_en;

    // Read wins over write when both are requested.
    assign wr_en = wr & ~rd;

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[addr] = data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign data = (rd && rst) ? mem_q[addr] : {DWIDTH{1'bz}};

`ifdef MEMORY_COLLISION_EN
    logic collision_q;
    logic collision_d;

    always_comb begin
        collision_d = wr & rd;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            collision_q <= 1'b0;
        end else begin
            collision_q <= collision_d;
        end
    end

    assign collision = collision_q;
`endif

endmodule : memory

// File: tb/tb_memory.sv
// Directed bench for memory: array reference model plus literal spot checks.
// Bus release is probed by driving the complement of the stored word and reading it back intact.
module tb_memory;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr  = 1'b0;
    logic       rd  = 1'b0;
    logic [4:0] addr = '0;
    logic [7:0] drv  = '0;
    logic       drv_en = 1'b0;
    wire  [7:0] data;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    logic [7:0] model [32];
    logic       exp_coll;

`ifdef MEMORY_COLLISION_EN
    logic collision;
`endif

    assign data = drv_en ? drv : 8'hzz;

    memory #(.AWIDTH(5), .DWIDTH(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .wr   (wr),
        .rd   (rd),
        .addr (addr),
        .data (data)
`ifdef MEMORY_COLLISION_EN
        ,
        .collision (collision)
`endif
    );

    always #5 clk = ~clk;

    // Reference: plain array, cleared on reset, written only for pure writes.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) model[i] = 8'h00;
            exp_coll = 1'b0;
        end else begin
            if (wr && !rd) model[addr] = data;
            exp_coll = wr && rd;
        end
    end

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic write_word(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        #1;
        addr = a; drv = d; drv_en = 1'b1; wr = 1'b1; rd = 1'b0;
        @(posedge clk);
        #1;
        wr = 1'b0; drv_en = 1'b0;
    endtask

    task automatic read_word(input string name, input logic [4:0] a, input logic [7:0] exp);
        @(negedge clk);
        #1;
        wr = 1'b0; drv_en = 1'b0; rd = 1'b1; addr = a;
        #1;
        check(name, data, exp);
    endtask

    // With rd low the bench drives val; any DUT drive would corrupt it.
    task automatic probe_release(input string name, input logic [7:0] val);
        drv = val; drv_en = 1'b1;
        #1;
        check(name, data, val);
        drv_en = 1'b0;
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (rst && rd && !drv_en) check("model_read", data, model[addr]);
`ifdef MEMORY_COLLISION_EN
                if (rst) check("model_collision", {7'b0, collision}, {7'b0, exp_coll});
`endif
            end
        join_none

        // Reset held for two cycles.
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        read_word("reset_addr7", 5'd7, 8'h00);
`ifdef MEMORY_COLLISION_EN
        check("reset_collision", {7'b0, collision}, 8'h00);
`endif
        rd = 1'b0;
        probe_release("reset_release", 8'hFF);

        // Boundary addresses with all-ones / all-zeros data.
        write_word(5'd0, 8'hFF);
        write_word(5'd31, 8'h00);
        read_word("bound_addr0", 5'd0, 8'hFF);
        read_word("bound_addr31", 5'd31, 8'h00);

        // Sweep: addr 31-k gets k; addr 0 keeps 8'hFF.
        for (int k = 0; k <= 30; k++) write_word(5'(31 - k), 8'(k));
        read_word("sweep_addr0", 5'd0, 8'hFF);
        for (int a = 1; a < 32; a++) read_word($sformatf("sweep_addr%0d", a), 5'(a), 8'(31 - a));

        // Collision: read wins, memory untouched.
        write_word(5'd3, 8'hA5);
        @(negedge clk);
        #1;
        addr = 5'd3; drv_en = 1'b0; wr = 1'b1; rd = 1'b1;
        #1;
        check("collision_read", data, 8'hA5);
        @(posedge clk);
        #1;
        wr = 1'b0;
`ifdef MEMORY_COLLISION_EN
        check("collision_flag_set", {7'b0, collision}, 8'h01);
`endif
        check("collision_keep", data, 8'hA5);
        @(posedge clk);
        #1;
`ifdef MEMORY_COLLISION_EN
        check("collision_flag_clr", {7'b0, collision}, 8'h00);
`endif

        // Release with addr stable, no clock edge involved.
        check("release_before", data, 8'hA5);
        rd = 1'b0;
        probe_release("release_addr3", 8'h5A);

        // Mid-cycle reset clears contents and releases the bus immediately.
        write_word(5'd9, 8'h3C);
        read_word("pre_reset_addr9", 5'd9, 8'h3C);
        #1 rst = 1'b0;
        probe_release("reset_drop_release", 8'hC3);
        @(posedge clk);
        #2 rst = 1'b1;
        read_word("post_reset_addr9", 5'd9, 8'h00);
        read_word("post_reset_addr0", 5'd0, 8'h00);
        read_word("post_reset_addr3", 5'd3, 8'h00);
        write_word(5'd9, 8'h81);
        read_word("post_reset_write", 5'd9, 8'h81);

        @(negedge clk);
        #1 rd = 1'b0;
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_memory
